// File: rtl/mux_2x1_rr_arbiter_pkg.sv
// Shared types and constants for the 2:1 round-robin arbiter slice.
// Holds the lock-FSM state encodings, the source indices and the default data width.
package mux_2x1_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_e;

  localparam logic SRC_IN0        = 1'b0;
  localparam logic SRC_IN1        = 1'b1;
  localparam int   DEFAULT_DATA_W = 8;

  // Lock state that pins arbitration to the given source.
  function automatic arb_state_e lock_state_for(input logic src);
    lock_state_for = (src == SRC_IN1) ? ARB_LOCK1 : ARB_LOCK0;
  endfunction

endpackage

// File: rtl/mux_2x1_rr_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared consumer.
// MUX_ARB_LOCK_EN adds the per-requester packet-last flags.
interface mux_2x1_rr_arbiter_if
  import mux_2x1_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;

`ifdef MUX_ARB_LOCK_EN
  logic              in0_last;
  logic              in1_last;

  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );
`else
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/mux_2x1_rr_arbiter_pick.sv
// Combinational two-way round-robin winner pick (rr_pick2).
// A lock state pins the grant to one source regardless of the other request.
module rr_pick2
  import mux_2x1_rr_arbiter_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  input  arb_state_e lock_state_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  // Winner selection: locked source first, otherwise alternate on ties.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = SRC_IN0;
    case (lock_state_i)
      ARB_LOCK0: begin
        grant_valid_o = valid0_i;
        grant_idx_o   = SRC_IN0;
      end
      ARB_LOCK1: begin
        grant_valid_o = valid1_i;
        grant_idx_o   = SRC_IN1;
      end
      default: begin
        if (valid0_i && valid1_i) begin
          grant_valid_o = 1'b1;
          grant_idx_o   = ~last_grant_i;
        end else if (valid0_i) begin
          grant_valid_o = 1'b1;
          grant_idx_o   = SRC_IN0;
        end else if (valid1_i) begin
          grant_valid_o = 1'b1;
          grant_idx_o   = SRC_IN1;
        end else begin
          grant_valid_o = 1'b0;
          grant_idx_o   = SRC_IN0;
        end
      end
    endcase
  end

endmodule

// File: rtl/mux_2x1_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output slot.
// Optional MUX_ARB_LOCK_EN: packet lock via in*_last held in an IDLE/LOCK0/LOCK1 FSM.
module mux_2x1_rr_arbiter
  import mux_2x1_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input logic                 clk,
  input logic                 rst_n,
  mux_2x1_rr_arbiter_if.slave bus
);

  logic              slot_free_s;
  logic              grant_valid_s;
  logic              grant_idx_s;
  logic              xfer_s;
  logic [DATA_W-1:0] win_data_s;
  arb_state_e        lock_state_s;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_sel_q,   out_sel_d;
  logic              last_grant_q, last_grant_d;

  // The slot can take a beat when empty or when being drained this cycle.
  assign slot_free_s = !out_valid_q || bus.out_ready;

  rr_pick2 u_pick (
    .valid0_i      (bus.in0_valid),
    .valid1_i      (bus.in1_valid),
    .last_grant_i  (last_grant_q),
    .lock_state_i  (lock_state_s),
    .grant_valid_o (grant_valid_s),
    .grant_idx_o   (grant_idx_s)
  );

  assign xfer_s        = rst_n && slot_free_s && grant_valid_s;
  assign bus.in0_ready = xfer_s && (grant_idx_s == SRC_IN0);
  assign bus.in1_ready = xfer_s && (grant_idx_s == SRC_IN1);
  assign win_data_s    = (grant_idx_s == SRC_IN1) ? bus.in1_data : bus.in0_data;

  // Slot and pointer next-state: load on transfer, empty on idle drain, else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (xfer_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = win_data_s;
      out_sel_d    = grant_idx_s;
      last_grant_d = grant_idx_s;
    end else if (slot_free_s) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // Slot and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= SRC_IN0;
      last_grant_q <= SRC_IN1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef MUX_ARB_LOCK_EN
  arb_state_e state_q, state_d;
  logic       win_last_s;

  assign win_last_s = (grant_idx_s == SRC_IN1) ? bus.in1_last : bus.in0_last;

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock FSM next state: a non-last beat opens a lock, the last beat closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (xfer_s && !win_last_s) begin
          state_d = lock_state_for(grant_idx_s);
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        if (xfer_s && win_last_s) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Lock FSM output: the current lock steers the picker.
  always_comb begin
    lock_state_s = state_q;
  end
`else
  assign lock_state_s = ARB_IDLE;
`endif

endmodule
